// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg -- definitions shared by the program-counter controller.
//   state_t    : controller state encoding (IDLE, INIT, RUN, DONE)
//   PC_W       : program counter / destination width
//   CNT_W      : executed-cycle counter width
//   pc_plus1() : return address of an instruction (wraps at PC_W bits)
package pc_ctrl_pkg;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [PC_W-1:0] pc_plus1(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_ctrl_ras.sv
// ras_stack -- return-address stack for pc_ctrl (only built with PC_CTRL_RAS_EN).
// Ports:
//   CLK, Reset  : clock, asynchronous active-high reset (empties the stack)
//   push        : store push_data on top (ignored when full)
//   pop         : discard top entry (ignored when empty)
//   push_data   : return address to store
//   full, empty : occupancy flags
//   top         : current top entry, combinational (0 when empty)
// The top entry is read combinationally because a return redirects the PC
// in the same cycle it is decoded; the storage is therefore a small
// register array rather than a block RAM with registered read.
module ras_stack
    import pc_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] top
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp_reg;
    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp_reg == SP_W'(DEPTH));
    assign empty   = (sp_reg == '0);
    assign top_idx = IDX_W'(sp_reg - SP_W'(1));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sp_reg <= '0;
        end else if (push && !full) begin
            sp_reg <= sp_reg + SP_W'(1);
        end else if (pop && !empty) begin
            sp_reg <= sp_reg - SP_W'(1);
        end
    end

    // Storage carries no reset: entries above the stack pointer are never read.
    always_ff @(posedge CLK) begin
        if (push && !full) begin
            mem[sp_reg[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl -- program-counter controller: start-up sequencing, jump/branch
// steering, run-cycle accounting and an optional return-address stack.
// Build option: define PC_CTRL_RAS_EN to enable call/return through the
// ras_stack sub-module; otherwise calls act as jumps and returns are ignored.
// Ports:
//   CLK, Reset          : clock, asynchronous active-high reset
//   start               : program request (level)
//   halt_in             : program counter reports halt
//   pc_in               : current program counter
//   is_jump/is_branch/is_call/is_ret : decoded instruction class
//   cond_flag           : branch condition
//   target              : absolute jump/call destination
//   init                : synchronous reset to the program counter
//   jump_en, branch_en  : program counter steering
//   destination         : jump destination (0 when not jumping)
//   done                : program complete
//   cycle_cnt           : executed RUN cycles (saturating)
//   ras_err             : sticky stack overflow/underflow
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int RAS_DEPTH   = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             halt_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             is_call,
    input  logic             is_ret,
    input  logic             cond_flag,
    input  logic [PC_W-1:0]  target,
    output logic             init,
    output logic             jump_en,
    output logic             branch_en,
    output logic [PC_W-1:0]  destination,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             ras_err
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t             state_reg, state_next;
    logic [INIT_W-1:0]  init_cnt_reg;
    logic [CNT_W-1:0]   cycle_cnt_reg;
    logic               steer_ok;

    // An instruction only executes in RUN when the PC is not halting.
    assign steer_ok  = (state_reg == ST_RUN) && !halt_in;
    assign cycle_cnt = cycle_cnt_reg;

`ifdef PC_CTRL_RAS_EN
    logic            ras_push, ras_pop, ras_err_set;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;
    logic            ras_err_reg;

    ras_stack #(
        .DEPTH     (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus1(pc_in)),
        .full      (ras_full),
        .empty     (ras_empty),
        .top       (ras_top)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ras_err_reg <= 1'b0;
        end else if (ras_err_set) begin
            ras_err_reg <= 1'b1;
        end
    end

    assign ras_err = ras_err_reg;
`else
    localparam int ras_depth_unused = RAS_DEPTH;
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{is_ret, pc_in};
    assign ras_err = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_INIT;
            ST_INIT: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else if (init_cnt_reg == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  if (halt_in) state_next = ST_DONE;
            ST_DONE: if (!start) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / steering logic
    always_comb begin
        init        = 1'b0;
        done        = 1'b0;
        jump_en     = 1'b0;
        branch_en   = 1'b0;
        destination = '0;
`ifdef PC_CTRL_RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_err_set = 1'b0;
`endif
        case (state_reg)
            ST_IDLE, ST_INIT: init = 1'b1;
            ST_DONE:          done = 1'b1;
            default: ;
        endcase

        if (steer_ok) begin
`ifdef PC_CTRL_RAS_EN
            if (is_ret) begin
                // A return on an empty stack falls through to PC+1.
                if (!ras_empty) begin
                    ras_pop     = 1'b1;
                    jump_en     = 1'b1;
                    destination = ras_top;
                end else begin
                    ras_err_set = 1'b1;
                end
            end else if (is_call) begin
                // The call is taken even when the return address is lost.
                jump_en     = 1'b1;
                destination = target;
                if (!ras_full) begin
                    ras_push = 1'b1;
                end else begin
                    ras_err_set = 1'b1;
                end
            end else if (is_jump) begin
                jump_en     = 1'b1;
                destination = target;
            end else if (is_branch) begin
                branch_en = cond_flag;
            end
`else
            if (is_call || is_jump) begin
                jump_en     = 1'b1;
                destination = target;
            end else if (is_branch) begin
                branch_en = cond_flag;
            end
`endif
        end
    end

    // Init hold counter: loaded on IDLE->INIT, counts down to zero in INIT.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            init_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            init_cnt_reg <= INIT_W'(INIT_CYCLES - 1);
        end else if (state_reg == ST_INIT && init_cnt_reg != '0) begin
            init_cnt_reg <= init_cnt_reg - INIT_W'(1);
        end
    end

    // Run-cycle counter. The halting cycle executes nothing, so the value
    // observed alongside halt_in is the one frozen in DONE.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cycle_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            cycle_cnt_reg <= '0;
        end else if (steer_ok && cycle_cnt_reg != CNT_MAX) begin
            cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
        end
    end

endmodule
